// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-slices a double-buffered
// hex value across NDIG digit strobes, with optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int unsigned NDIG     = 6,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                load,
    input  logic [4*NDIG-1:0]   value,
    input  logic                lz_sup,
    output logic [3:0]          hex_out,
    output logic [NDIG-1:0]     dig_sel,
    output logic                frame_done,
    output logic                pending
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW = (NDIG > 2) ? $clog2(NDIG) : 1;
    localparam int unsigned VW = 4 * NDIG;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [VW-1:0]   shadow_q, shadow_d;
    logic [VW-1:0]   active_q, active_d;
    logic            pending_q, pending_d;
    logic            frame_done_q, frame_done_d;
    logic [NDIG-1:0] dig_sel_q, dig_sel_d;
    logic [3:0]      hex_q, hex_d;

    logic            show_c;
    logic            zero_run_c;
    logic [NDIG-1:0] blank_c;

    // Next-state: scan sequencing, buffer transfer, and the strobe/nibble to present
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        presc_d      = presc_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        show_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d   = '0;
                presc_d = '0;
                // Nothing is on screen, so an unqueued load can go straight to the display
                if (load) begin
                    shadow_d = value;
                    if (!pending_q) begin
                        active_d = value;
                    end
                end
                if (enable) begin
                    state_d = ST_SCAN;
                    show_c  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    presc_d = '0;
                end else begin
                    show_c = 1'b1;
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            // Swap only between frames so no frame mixes two values
                            if (pending_q) begin
                                active_d  = shadow_q;
                                pending_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                // Applied after the transfer so a wrap-edge load queues for the next frame
                if (load) begin
                    shadow_d  = value;
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Digit i is blank when it and every more significant digit are zero
        zero_run_c = 1'b1;
        blank_c    = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run_c = zero_run_c && (active_d[4*i +: 4] == 4'h0);
            blank_c[i] = zero_run_c;
        end

        dig_sel_d = '0;
        hex_d     = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (show_c && (idx_d == IW'(i)) && !(lz_sup && blank_c[i])) begin
                dig_sel_d[i] = 1'b1;
                hex_d        = active_d[4*i +: 4];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            presc_q      <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            dig_sel_q    <= '0;
            hex_q        <= 4'h0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            presc_q      <= presc_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            dig_sel_q    <= dig_sel_d;
            hex_q        <= hex_d;
        end
    end

    assign hex_out    = hex_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (NDIG=4, TICK_DIV=3): vector table, directed corner
// sequences and randomized traffic against a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned NDIG = 4;
    localparam int unsigned TD   = 3;
    localparam int unsigned FR   = NDIG * TD;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        lz_sup;
    logic [3:0]  hex_out;
    logic [3:0]  dig_sel;
    logic        frame_done;
    logic        pending;

    seg_scan_ctrl #(
        .NDIG     (NDIG),
        .TICK_DIV (TD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .lz_sup     (lz_sup),
        .hex_out    (hex_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within the frame as a single cycle count
    bit          m_scan;
    int unsigned m_t;
    logic [15:0] m_act;
    logic [15:0] m_sh;
    bit          m_pend;
    bit          m_fd;
    bit          cur_en;
    bit          cur_lz;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        lz;
        logic [3:0]  sel;
        logic [3:0]  hex;
        logic        fd;
        logic        pend;
    } vec_t;

    vec_t vtab [17];

    task automatic model_reset();
        m_scan = 0;
        m_t    = 0;
        m_act  = 16'h0;
        m_sh   = 16'h0;
        m_pend = 0;
        m_fd   = 0;
    endtask

    task automatic model_step(input bit r, input bit e, input bit l, input logic [15:0] v);
        m_fd = 0;
        if (r) begin
            model_reset();
        end else if (!m_scan) begin
            if (l) begin
                m_sh = v;
                if (!m_pend) m_act = v;
            end
            if (e) begin
                m_scan = 1;
                m_t    = 0;
            end
        end else if (!e) begin
            m_scan = 0;
            m_t    = 0;
            if (l) begin
                m_sh   = v;
                m_pend = 1;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == FR) begin
                m_t  = 0;
                m_fd = 1;
                if (m_pend) begin
                    m_act  = m_sh;
                    m_pend = 0;
                end
            end
            if (l) begin
                m_sh   = v;
                m_pend = 1;
            end
        end
    endtask

    task automatic model_out(output logic [3:0] s, output logic [3:0] h);
        int unsigned d;
        logic [15:0] upper;
        s = 4'h0;
        h = 4'h0;
        if (m_scan) begin
            d     = m_t / TD;
            upper = m_act >> (4 * d);
            if (d == 0 || !cur_lz || upper != 16'h0) begin
                s = 4'(1 << d);
                h = upper[3:0];
            end
        end
    endtask

    task automatic compare(input string name, input logic [3:0] es, input logic [3:0] eh,
                           input logic ef, input logic ep);
        n_cmp++;
        if (dig_sel !== es || hex_out !== eh || frame_done !== ef || pending !== ep) begin
            n_err++;
            $display("FAIL %s: got sel=%b hex=%h fd=%b pend=%b, want sel=%b hex=%h fd=%b pend=%b",
                     name, dig_sel, hex_out, frame_done, pending, es, eh, ef, ep);
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0] s;
        logic [3:0] h;
        model_out(s, h);
        compare(name, s, h, m_fd, m_pend);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge
    task automatic apply(input bit r, input bit e, input bit l, input logic [15:0] v, input bit z);
        rst    = r;
        enable = e;
        load   = l;
        value  = v;
        lz_sup = z;
        cur_en = e;
        cur_lz = z;
        @(posedge clk);
        model_step(r, e, l, v);
        #1;
        load = 1'b0;
    endtask

    // Idle-scan until the model sits at frame position target, checking every cycle
    task automatic run_to(input int unsigned target, input string name);
        int n;
        n = 0;
        while (!(m_scan && m_t == target) && n < 40) begin
            apply(0, cur_en, 0, 16'h0, cur_lz);
            check_model(name);
            n++;
        end
        if (!(m_scan && m_t == target)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: frame position %0d not reached within 40 cycles", name, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, e, l;
        logic [15:0] v;
        bit          z;

        clk    = 0;
        rst    = 1;
        enable = 0;
        load   = 0;
        value  = 16'h0;
        lz_sup = 0;
        cur_en = 0;
        cur_lz = 0;
        model_reset();

        // Load 1234 while idle, then scan: 4,3,2,1 each 3 cycles, frame_done every 12
        vtab[0]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 4'b0000, 4'h0, 1'b0, 1'b0};
        vtab[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'h4, 1'b0, 1'b0};
        vtab[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'h4, 1'b0, 1'b0};
        vtab[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'h4, 1'b0, 1'b0};
        vtab[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0010, 4'h3, 1'b0, 1'b0};
        vtab[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0010, 4'h3, 1'b0, 1'b0};
        vtab[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0010, 4'h3, 1'b0, 1'b0};
        vtab[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0100, 4'h2, 1'b0, 1'b0};
        vtab[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0100, 4'h2, 1'b0, 1'b0};
        vtab[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0100, 4'h2, 1'b0, 1'b0};
        vtab[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b1000, 4'h1, 1'b0, 1'b0};
        vtab[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b1000, 4'h1, 1'b0, 1'b0};
        vtab[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b1000, 4'h1, 1'b0, 1'b0};
        vtab[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'h4, 1'b1, 1'b0};
        vtab[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'h4, 1'b0, 1'b0};
        vtab[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0001, 4'h4, 1'b0, 1'b0};
        vtab[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'b0010, 4'h3, 1'b0, 1'b0};

        // Reset state
        apply(1, 0, 0, 16'h0, 0);
        compare("reset", 4'b0000, 4'h0, 1'b0, 1'b0);
        apply(1, 1, 1, 16'hFFFF, 0);
        compare("reset_hold", 4'b0000, 4'h0, 1'b0, 1'b0);
        apply(0, 0, 0, 16'h0, 0);
        compare("idle", 4'b0000, 4'h0, 1'b0, 1'b0);

        // Basic frame
        for (int i = 0; i < 17; i++) begin
            apply(0, vtab[i].en, vtab[i].ld, vtab[i].val, vtab[i].lz);
            compare($sformatf("vec%0d", i), vtab[i].sel, vtab[i].hex, vtab[i].fd, vtab[i].pend);
        end

        // Load during digit-1 slot waits for the frame boundary
        apply(0, 1, 1, 16'hABCD, 0);
        compare("pend_set", 4'b0010, 4'h3, 1'b0, 1'b1);
        run_to(FR - 1, "pend_wait");
        apply(0, 1, 0, 16'h0, 0);
        compare("pend_xfer", 4'b0001, 4'hD, 1'b1, 1'b0);

        // Leading-zero suppression
        apply(0, 1, 1, 16'h0050, 1);
        check_model("lz_load");
        run_to(FR - 1, "lz_wait");
        apply(0, 1, 0, 16'h0, 1);
        compare("lz_d0", 4'b0001, 4'h0, 1'b1, 1'b0);
        run_to(3, "lz_run1");
        compare("lz_d1", 4'b0010, 4'h5, 1'b0, 1'b0);
        run_to(6, "lz_run2");
        compare("lz_d2", 4'b0000, 4'h0, 1'b0, 1'b0);
        run_to(9, "lz_run3");
        compare("lz_d3", 4'b0000, 4'h0, 1'b0, 1'b0);
        apply(0, 1, 1, 16'h0000, 1);
        run_to(FR - 1, "zero_wait");
        apply(0, 1, 0, 16'h0, 1);
        compare("zero_d0", 4'b0001, 4'h0, 1'b1, 1'b0);
        run_to(3, "zero_run1");
        compare("zero_d1", 4'b0000, 4'h0, 1'b0, 1'b0);

        // Load on the wrap edge: old shadow shown, new one stays queued
        apply(0, 1, 1, 16'h1111, 0);
        run_to(FR - 1, "wl_wait");
        apply(0, 1, 1, 16'h2222, 0);
        compare("wrap_load", 4'b0001, 4'h1, 1'b1, 1'b1);
        run_to(FR - 1, "wl_wait2");
        apply(0, 1, 0, 16'h0, 0);
        compare("wrap_load_next", 4'b0001, 4'h2, 1'b1, 1'b0);

        // Disable in digit-2 slot, then re-enable
        run_to(6, "dis_wait");
        apply(0, 0, 0, 16'h0, 0);
        compare("dis_d2", 4'b0000, 4'h0, 1'b0, 1'b0);
        apply(0, 0, 0, 16'h0, 0);
        compare("dis_idle", 4'b0000, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            apply(0, 1, 0, 16'h0, 0);
            compare($sformatf("reen_c%0d", c), 4'b0001, 4'h2, 1'b0, 1'b0);
        end
        apply(0, 1, 0, 16'h0, 0);
        compare("reen_d1", 4'b0010, 4'h2, 1'b0, 1'b0);

        // Asynchronous reset with data pending in the digit-3 slot
        run_to(9, "rst_wait");
        apply(0, 1, 1, 16'h7777, 0);
        compare("pre_rst", 4'b1000, 4'h2, 1'b0, 1'b1);
        rst = 1'b1;
        #2;
        compare("async_rst", 4'b0000, 4'h0, 1'b0, 1'b0);
        model_reset();
        apply(1, 1, 0, 16'h0, 0);
        compare("rst_held", 4'b0000, 4'h0, 1'b0, 1'b0);
        apply(0, 0, 1, 16'h4321, 0);
        compare("reload", 4'b0000, 4'h0, 1'b0, 1'b0);
        apply(0, 1, 0, 16'h0, 0);
        compare("reload_d0", 4'b0001, 4'h1, 1'b0, 1'b0);
        run_to(FR - 1, "reload_wait");
        apply(0, 1, 0, 16'h0, 0);
        compare("reload_wrap", 4'b0001, 4'h1, 1'b1, 1'b0);

        // Randomized traffic against the model
        z = 0;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 5) == 0);
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) z = !z;
            apply(r, e, l, v, z);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 6: number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 50000: clk cycles per digit slot (>=2).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 enable  input  1  1 = scan digits, 0 = display dark.
REQ-007 load  input  1  single-cycle request to capture value.
REQ-008 value  input  4*NDIG  hex nibbles; digit i = value[4i+3:4i]; digit NDIG-1 is the MSB.
REQ-009 lz_sup  input  1  1 = suppress leading zeros.
REQ-010 hex_out  output  4  nibble driven to the shared hex-to-7seg decoder.
REQ-011 dig_sel  output  NDIG  one-hot, active-high digit strobe; all-zero = dark.
REQ-012 frame_done  output  1  one-cycle pulse after the last digit slot of each frame.
REQ-013 pending  output  1  a captured value is waiting for frame-boundary transfer.

Function
REQ-014 All outputs SHALL be registered; no combinational path from input to output.
REQ-015 State machine SHALL have two states: IDLE (dig_sel=0, prescaler held at 0, idx=0) and SCAN.
REQ-016 IDLE->SCAN SHALL occur on the first clk edge with enable=1; dig_sel selects digit 0 on that edge.
REQ-017 SCAN->IDLE SHALL occur on the first edge with enable=0; dig_sel=0, idx=0 and prescaler=0 on that edge, and no frame_done is pulsed.
REQ-018 In SCAN, the prescaler SHALL count 0..TICK_DIV-1; each digit slot SHALL last exactly TICK_DIV cycles.
REQ-019 At prescaler wrap, idx SHALL advance by 1 and SHALL wrap from NDIG-1 to 0.
REQ-020 frame_done SHALL pulse for 1 cycle on the edge where idx wraps NDIG-1 -> 0.
REQ-021 hex_out SHALL equal the active-buffer nibble of the currently selected digit, updated on the same edge as dig_sel.
REQ-022 Double buffering: load=1 SHALL copy value into the shadow register and set pending=1 on the next edge.
REQ-023 A second load while pending=1 SHALL overwrite the shadow (last wins).
REQ-024 At the NDIG-1 -> 0 wrap, if pending=1, the active buffer SHALL take the shadow and pending SHALL clear; digit 0 of the new frame SHALL already show the new value.
REQ-025 A load on the wrap edge SHALL write the shadow after the transfer (the transfer uses the old shadow) and SHALL leave pending=1.
REQ-026 In IDLE, load with pending=0 SHALL write both the shadow and the active buffer directly, and pending SHALL stay 0.
REQ-027 Leading-zero suppression (lz_sup=1): digit i>0 SHALL be dark (dig_sel all zero during its slot, hex_out=0) when digits NDIG-1..i of the active buffer are all 0.
REQ-028 Digit 0 SHALL never be suppressed; slot timing SHALL be unchanged by suppression.
REQ-029 With lz_sup=0, every digit SHALL be shown.
REQ-030 At most one dig_sel bit SHALL be high in any cycle.

Reset
REQ-031 While rst=1, the block SHALL hold state=IDLE, idx=0, prescaler=0, shadow=0, active=0, pending=0, dig_sel=0, hex_out=0 and frame_done=0.
REQ-032 Reset asserted mid-frame SHALL take effect immediately and discard pending data.
REQ-033 After rst falls with enable=1, digit 0 SHALL be selected on the first clk edge.

Verification (NDIG=4, TICK_DIV=3)
REQ-034 Reset, then enable=1 with value=16'h1234 loaded in IDLE -> dig_sel sequence 0001,0010,0100,1000 with hex_out 4,3,2,1, each held 3 cycles, and frame_done pulses every 12 cycles.
REQ-035 While scanning 16'h1234, load 16'hABCD in the digit-1 slot -> pending=1 until the wrap, then the first slot shows hex_out=D and pending=0.
REQ-036 lz_sup=1 with value 16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; value 16'h0000 -> only digit 0 lit, showing 0.
REQ-037 load asserted on the wrap edge while pending=1 -> the older shadow is displayed and pending remains 1 until the next wrap.
REQ-038 Drop enable in the digit-2 slot -> dig_sel=0 on the next edge with no frame_done; re-enable -> restart at digit 0 with a full 3-cycle slot.
REQ-039 Assert rst in the digit-3 slot with pending=1 -> all outputs 0 asynchronously; the value reloaded afterward is displayed, not the old shadow.
